// File: rtl/block_tiled_mm_pkg.sv
// block_tiled_mm_pkg: shared FSM states, tile geometry and saturating arithmetic
package block_tiled_mm_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;
    localparam int DRAIN_CYCLES = 7;
    localparam int TILE_DIM = 4;

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int bw);
        logic signed [63:0] s, hi, lo;
        s = a + b;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return s > hi ? hi : (s < lo ? lo : s);
    endfunction
endpackage

// File: rtl/mm_tile_4x4.sv
// mm_tile_4x4: output-stationary 4x4 fixed-point MAC tile with internal input skew
module mm_tile_4x4 import block_tiled_mm_pkg::*; #(
    parameter int BIT_WIDTH = 16,
    parameter int FRAC_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          acc_clr,
    input  logic [TILE_DIM*BIT_WIDTH-1:0] in_north,
    input  logic [TILE_DIM*BIT_WIDTH-1:0] in_west,
    input  logic [1:0]                    row_sel,
    output logic [TILE_DIM*BIT_WIDTH-1:0] out_row,
    output logic [TILE_DIM*TILE_DIM-1:0]  sat
);
    localparam int BW = BIT_WIDTH;
    logic signed [BW-1:0] w_sk [TILE_DIM];
    logic signed [BW-1:0] n_sk [TILE_DIM];
    logic signed [BW-1:0] a_r  [TILE_DIM][TILE_DIM];
    logic signed [BW-1:0] b_r  [TILE_DIM][TILE_DIM];
    logic signed [BW-1:0] acc  [TILE_DIM][TILE_DIM];
    logic signed [63:0]   p    [TILE_DIM][TILE_DIM];
    logic signed [63:0]   raw  [TILE_DIM][TILE_DIM];
    logic signed [63:0]   clip [TILE_DIM][TILE_DIM];

    genvar i;
    for (i = 0; i < TILE_DIM; i++) begin : g_skew
        logic signed [BW-1:0] w_in, n_in;
        assign w_in = in_west[(TILE_DIM-i)*BW-1 -: BW];
        assign n_in = in_north[(TILE_DIM-i)*BW-1 -: BW];
        if (i == 0) begin : g_direct
            assign w_sk[i] = w_in;
            assign n_sk[i] = n_in;
        end else begin : g_delay
            logic signed [BW-1:0] w_sr [i];
            logic signed [BW-1:0] n_sr [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w_sr <= '{default: '0};
                    n_sr <= '{default: '0};
                end else begin
                    w_sr[0] <= w_in;
                    n_sr[0] <= n_in;
                    for (int d = 1; d < i; d++) begin
                        w_sr[d] <= w_sr[d-1];
                        n_sr[d] <= n_sr[d-1];
                    end
                end
            end
            assign w_sk[i] = w_sr[i-1];
            assign n_sk[i] = n_sr[i-1];
        end
    end

    // Sum kept at full product width so an oversized product clips instead of wrapping
    always_comb begin
        sat = '0;
        for (int r = 0; r < TILE_DIM; r++)
            for (int c = 0; c < TILE_DIM; c++) begin
                p[r][c] = (64'(a_r[r][c]) * 64'(b_r[r][c])) >>> FRAC_WIDTH;
                raw[r][c] = 64'(acc[r][c]) + p[r][c];
                clip[r][c] = sat_add(64'(acc[r][c]), p[r][c], BW);
                sat[r*TILE_DIM+c] = clip[r][c] != raw[r][c];
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '{default: '0};
            b_r <= '{default: '0};
            acc <= '{default: '0};
        end else begin
            for (int r = 0; r < TILE_DIM; r++) begin
                a_r[r][0] <= w_sk[r];
                b_r[0][r] <= n_sk[r];
                for (int c = 1; c < TILE_DIM; c++) begin
                    a_r[r][c] <= a_r[r][c-1];
                    b_r[c][r] <= b_r[c-1][r];
                end
            end
            for (int r = 0; r < TILE_DIM; r++)
                for (int c = 0; c < TILE_DIM; c++)
                    acc[r][c] <= acc_clr ? '0 : clip[r][c][BW-1:0];
        end
    end

    always_comb begin
        out_row = '0;
        for (int c = 0; c < TILE_DIM; c++)
            out_row[(TILE_DIM-c)*BW-1 -: BW] = acc[row_sel][c];
    end
endmodule

// File: rtl/block_tiled_mm.sv
// block_tiled_mm: streaming wrapper around NUM_TILES 4x4 MAC tiles (load, drain, row-by-row output)
module block_tiled_mm import block_tiled_mm_pkg::*; #(
    parameter int BIT_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int NUM_TILES = 8,
    parameter int K_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_TILES*TILE_DIM*BIT_WIDTH-1:0] in_north,
    input  logic [NUM_TILES*TILE_DIM*BIT_WIDTH-1:0] in_west,
    input  logic                                   acc_keep,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_TILES*TILE_DIM*BIT_WIDTH-1:0] out_row,
    output logic [1:0]                             out_row_idx,
    output logic                                   busy,
    output logic                                   sat_flag
);
    localparam int TW = TILE_DIM * BIT_WIDTH;
    localparam int KW = $clog2(K_DEPTH) + 1;
    state_t state;
    logic [KW-1:0] k_cnt;
    logic [2:0] d_cnt;
    logic in_fire, out_fire, last_beat, acc_clr;
    logic [NUM_TILES*TW-1:0] north_g, west_g;
    logic [NUM_TILES*TILE_DIM*TILE_DIM-1:0] sat_all;

    assign in_fire = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign last_beat = out_fire & (out_row_idx == 2'd3);
    assign acc_clr = last_beat & ~acc_keep;
    // Idle cycles feed zeros so bubbles only shift data through the array
    assign north_g = in_fire ? in_north : '0;
    assign west_g = in_fire ? in_west : '0;
    assign busy = state != IDLE;

    genvar t;
    for (t = 0; t < NUM_TILES; t++) begin : g_tile
        mm_tile_4x4 #(.BIT_WIDTH(BIT_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_tile (
            .clk(clk),
            .rst_n(rst_n),
            .acc_clr(acc_clr),
            .in_north(north_g[(t+1)*TW-1 -: TW]),
            .in_west(west_g[(t+1)*TW-1 -: TW]),
            .row_sel(out_row_idx),
            .out_row(out_row[(t+1)*TW-1 -: TW]),
            .sat(sat_all[t*TILE_DIM*TILE_DIM +: TILE_DIM*TILE_DIM])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k_cnt <= '0;
            d_cnt <= '0;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            out_row_idx <= 2'd0;
            sat_flag <= 1'b0;
        end else begin
            sat_flag <= acc_clr ? 1'b0 : sat_flag | (|sat_all);
            case (state)
                IDLE, LOAD: if (in_fire) begin
                    if (k_cnt == KW'(K_DEPTH - 1)) begin
                        state <= DRAIN;
                        k_cnt <= '0;
                        d_cnt <= '0;
                        in_ready <= 1'b0;
                    end else begin
                        state <= LOAD;
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                DRAIN: if (d_cnt == 3'(DRAIN_CYCLES - 1)) begin
                    state <= OUT;
                    out_valid <= 1'b1;
                end else begin
                    d_cnt <= d_cnt + 1'b1;
                end
                OUT: if (out_fire) begin
                    out_row_idx <= out_row_idx + 1'b1;
                    if (last_beat) begin
                        state <= IDLE;
                        out_valid <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_tiled_mm.sv
// tb_block_tiled_mm: randomized scenarios against a plain-arithmetic matrix model
module tb_block_tiled_mm;
    localparam int BW = 16, FRAC = 8, NT = 2, KD = 4, W = NT * 4 * BW;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, acc_keep = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, busy, sat_flag;
    logic [W-1:0] in_north = '0, in_west = '0, out_row;
    logic [1:0] out_row_idx;

    int checks = 0, errors = 0;
    int a_m [NT][4][KD];
    int b_m [NT][KD][4];
    longint macc [NT][4][4];
    longint exp_c [NT][4][4];
    bit msat = 0, exp_sat;
    logic [W-1:0] got [4];
    logic [1:0] got_idx [4];
    logic [W-1:0] saved [4];
    int lat;
    bit tmo, busy_ok, stable_ok, rdy_ok, sat_at_out, ready_after, sat_after, busy_after;

    always #5 clk = ~clk;

    block_tiled_mm #(.BIT_WIDTH(BW), .FRAC_WIDTH(FRAC), .NUM_TILES(NT), .K_DEPTH(KD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_north(in_north), .in_west(in_west), .acc_keep(acc_keep),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .busy(busy), .sat_flag(sat_flag)
    );

    function automatic logic [W-1:0] slice_w(input int k);
        logic [W-1:0] v = '0;
        for (int t = 0; t < NT; t++)
            for (int i = 0; i < 4; i++) v[(t+1)*4*BW-1-i*BW -: BW] = 16'(a_m[t][i][k]);
        return v;
    endfunction

    function automatic logic [W-1:0] slice_n(input int k);
        logic [W-1:0] v = '0;
        for (int t = 0; t < NT; t++)
            for (int j = 0; j < 4; j++) v[(t+1)*4*BW-1-j*BW -: BW] = 16'(b_m[t][k][j]);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_row(input int r);
        logic [W-1:0] v = '0;
        for (int t = 0; t < NT; t++)
            for (int j = 0; j < 4; j++) v[(t+1)*4*BW-1-j*BW -: BW] = 16'(exp_c[t][r][j]);
        return v;
    endfunction

    // C += A*B with each k term floored to Q8.8 and the running sum clipped to 16-bit range
    task automatic model_pass(input bit keep);
        longint s;
        for (int t = 0; t < NT; t++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    for (int k = 0; k < KD; k++) begin
                        s = macc[t][i][j] + ((longint'(a_m[t][i][k]) * b_m[t][k][j]) >>> FRAC);
                        if (s > 32767) begin s = 32767; msat = 1; end
                        if (s < -32768) begin s = -32768; msat = 1; end
                        macc[t][i][j] = s;
                    end
                    exp_c[t][i][j] = macc[t][i][j];
                end
        exp_sat = msat;
        if (!keep) begin
            macc = '{default: 0};
            msat = 0;
        end
    endtask

    task automatic fill_random(input int rng);
        for (int t = 0; t < NT; t++)
            for (int x = 0; x < 4; x++)
                for (int k = 0; k < KD; k++) begin
                    a_m[t][x][k] = int'($urandom_range(0, 2 * rng)) - rng;
                    b_m[t][k][x] = int'($urandom_range(0, 2 * rng)) - rng;
                end
    endtask

    task automatic fill_const(input int a, input int b);
        for (int t = 0; t < NT; t++)
            for (int x = 0; x < 4; x++)
                for (int k = 0; k < KD; k++) begin
                    a_m[t][x][k] = a;
                    b_m[t][k][x] = b;
                end
    endtask

    task automatic fill_identity(input bit ramp);
        for (int t = 0; t < NT; t++)
            for (int x = 0; x < 4; x++)
                for (int k = 0; k < KD; k++) begin
                    a_m[t][x][k] = (x == k) ? 256 : 0;
                    b_m[t][k][x] = ramp ? 256 * (k + 1) + 16 * t * x : 256;
                end
    endtask

    // Runs one pass starting and ending on a falling edge; records outputs for the caller to judge
    task automatic do_pass(input int gap, input bit keep, input int hold);
        int n;
        logic [W-1:0] snap_row;
        logic [1:0] snap_idx;
        tmo = 0; busy_ok = 1; stable_ok = 1; rdy_ok = 1;
        for (int k = 0; k < KD; k++) begin
            if (k > 0)
                repeat (gap) begin
                    in_valid = 0;
                    in_north = {$urandom, $urandom, $urandom, $urandom};
                    in_west = {$urandom, $urandom, $urandom, $urandom};
                    @(negedge clk);
                    if (busy !== 1'b1) busy_ok = 0;
                end
            in_valid = 1; in_west = slice_w(k); in_north = slice_n(k);
            n = 0;
            while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            if (n == 20) tmo = 1;
            @(posedge clk);
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 0;
        end
        in_valid = 1;
        in_north = {$urandom, $urandom, $urandom, $urandom};
        in_west = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            if (busy !== 1'b1) busy_ok = 0;
            @(negedge clk);
            lat++;
        end
        if (lat == 50) tmo = 1;
        for (int b = 0; b < 4; b++) begin
            out_ready = 1;
            acc_keep = (b == 3) ? keep : 1'($urandom);
            if (b == 2 && hold > 0) begin
                out_ready = 0; snap_row = out_row; snap_idx = out_row_idx;
                repeat (hold) begin
                    @(negedge clk);
                    if (out_row !== snap_row || out_row_idx !== snap_idx || out_valid !== 1'b1) stable_ok = 0;
                    if (in_ready !== 1'b0) rdy_ok = 0;
                end
                out_ready = 1;
            end
            if (out_valid !== 1'b1) tmo = 1;
            if (in_ready !== 1'b0) rdy_ok = 0;
            if (busy !== 1'b1) busy_ok = 0;
            got[b] = out_row; got_idx[b] = out_row_idx;
            if (b == 0) sat_at_out = sat_flag;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 0; out_ready = 0; acc_keep = 0;
        ready_after = in_ready; sat_after = sat_flag; busy_after = busy;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_row !== '0) begin errors++; $display("FAIL reset_out_row got %h want 0", out_row); end
        checks++; if (out_row_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", out_row_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat_flag); end
    endtask

    task automatic test_identity();
        fill_identity(1);
        do_pass(0, 0, 0);
        model_pass(0);
        checks++; if (tmo) begin errors++; $display("FAIL ident_timeout got 1 want 0"); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL ident_latency got %0d want 7", lat); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL ident_busy got low want high throughout"); end
        for (int r = 0; r < 4; r++) begin
            checks++; if (got[r] !== exp_row(r)) begin errors++; $display("FAIL ident_row%0d got %h want %h", r, got[r], exp_row(r)); end
            checks++; if (got_idx[r] !== 2'(r)) begin errors++; $display("FAIL ident_idx got %0d want %0d", got_idx[r], r); end
            saved[r] = got[r];
        end
        checks++; if (sat_at_out !== 1'b0) begin errors++; $display("FAIL ident_sat got %b want 0", sat_at_out); end
        checks++; if (ready_after !== 1'b1 || busy_after !== 1'b0) begin errors++; $display("FAIL ident_idle got ready=%b busy=%b want 1 0", ready_after, busy_after); end
    endtask

    task automatic test_bubbles();
        fill_identity(1);
        do_pass(2, 0, 0);
        model_pass(0);
        checks++; if (lat !== 7 || tmo) begin errors++; $display("FAIL bubble_latency got %0d want 7", lat); end
        for (int r = 0; r < 4; r++) begin
            checks++; if (got[r] !== saved[r]) begin errors++; $display("FAIL bubble_row%0d got %h want %h", r, got[r], saved[r]); end
        end
    endtask

    task automatic test_saturation();
        fill_const(32512, 32512);
        do_pass(0, 0, 0);
        model_pass(0);
        for (int r = 0; r < 4; r++) begin
            checks++; if (got[r] !== {(NT*4){16'h7FFF}}) begin errors++; $display("FAIL satpos_row%0d got %h want all 7fff", r, got[r]); end
        end
        checks++; if (sat_at_out !== 1'b1) begin errors++; $display("FAIL satpos_flag got %b want 1", sat_at_out); end
        checks++; if (sat_after !== 1'b0) begin errors++; $display("FAIL satpos_clear got %b want 0", sat_after); end
        fill_const(-32512, 32512);
        do_pass(1, 0, 0);
        model_pass(0);
        for (int r = 0; r < 4; r++) begin
            checks++; if (got[r] !== {(NT*4){16'h8000}}) begin errors++; $display("FAIL satneg_row%0d got %h want all 8000", r, got[r]); end
        end
        checks++; if (sat_at_out !== exp_sat) begin errors++; $display("FAIL satneg_flag got %b want %b", sat_at_out, exp_sat); end
    endtask

    task automatic test_acc_keep();
        logic [W-1:0] want [3];
        bit keeps [3];
        want[0] = {(NT*4){16'h0100}}; want[1] = {(NT*4){16'h0200}}; want[2] = {(NT*4){16'h0100}};
        keeps[0] = 1; keeps[1] = 0; keeps[2] = 0;
        fill_identity(0);
        for (int p = 0; p < 3; p++) begin
            do_pass(0, keeps[p], 0);
            model_pass(keeps[p]);
            for (int r = 0; r < 4; r++) begin
                checks++; if (got[r] !== want[p] || got[r] !== exp_row(r)) begin errors++; $display("FAIL keep_pass%0d_row%0d got %h want %h", p, r, got[r], want[p]); end
            end
        end
    endtask

    task automatic test_backpressure();
        fill_random(2048);
        do_pass(1, 0, 5);
        model_pass(0);
        checks++; if (!stable_ok) begin errors++; $display("FAIL bp_stable got changing row/idx want held"); end
        checks++; if (!rdy_ok) begin errors++; $display("FAIL bp_in_ready got 1 during output want 0"); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", ready_after); end
        for (int r = 0; r < 4; r++) begin
            checks++; if (got[r] !== exp_row(r)) begin errors++; $display("FAIL bp_row%0d got %h want %h", r, got[r], exp_row(r)); end
        end
    endtask

    task automatic test_random();
        bit keep;
        for (int p = 0; p < 5; p++) begin
            fill_random(p == 4 ? 32767 : 1024 << p);
            keep = (p < 4) ? 1'($urandom) : 1'b0;
            do_pass(int'($urandom_range(0, 3)), keep, 0);
            model_pass(keep);
            for (int r = 0; r < 4; r++) begin
                checks++; if (got[r] !== exp_row(r)) begin errors++; $display("FAIL rand%0d_row%0d got %h want %h", p, r, got[r], exp_row(r)); end
            end
            checks++; if (sat_at_out !== exp_sat) begin errors++; $display("FAIL rand%0d_sat got %b want %b", p, sat_at_out, exp_sat); end
        end
    endtask

    task automatic test_reset_mid_load();
        fill_random(4096);
        do_pass(0, 1, 0);
        model_pass(1);
        for (int r = 0; r < 4; r++) begin
            checks++; if (got[r] !== exp_row(r)) begin errors++; $display("FAIL prereset_row%0d got %h want %h", r, got[r], exp_row(r)); end
        end
        fill_random(4096);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_west = slice_w(k); in_north = slice_n(k);
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 0;
        #1;
        test_reset();
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        macc = '{default: 0};
        msat = 0;
        @(negedge clk);
        fill_random(4096);
        do_pass(0, 0, 0);
        model_pass(0);
        for (int r = 0; r < 4; r++) begin
            checks++; if (got[r] !== exp_row(r)) begin errors++; $display("FAIL postreset_row%0d got %h want %h", r, got[r], exp_row(r)); end
        end
        checks++; if (lat !== 7 || tmo) begin errors++; $display("FAIL postreset_latency got %0d want 7", lat); end
    endtask

    initial begin
        macc = '{default: 0};
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1;
        @(negedge clk);
        test_identity();
        test_bubbles();
        test_saturation();
        test_acc_keep();
        test_backpressure();
        test_random();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish within 200000");
        $fatal(1, "watchdog");
    end
endmodule
